// File: rtl/mem_hs_pipe_pkg.sv
// Shared definitions for the handshake memory: state encoding, default
// geometry reused by the testbench, and parameter legality helpers.
package mem_hs_pipe_pkg;

    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_DEPTH      = 64;
    localparam int unsigned DEF_ADDR_WIDTH = 6;
    localparam int unsigned DEF_RD_LAT     = 1;

    localparam int unsigned RD_LAT_MIN = 1;
    localparam int unsigned RD_LAT_MAX = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    // True when a read latency lies in the supported pipeline range.
    function automatic bit rd_lat_ok(input int unsigned lat);
        return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
    endfunction

    // True when the address width can reach every word of the array.
    function automatic bit addr_width_ok(input int unsigned aw, input int unsigned depth);
        return (64'd1 << aw) >= 64'(depth);
    endfunction

endpackage

// File: rtl/mem_rd_pipe.sv
// Read-response pipeline: RD_LAT stages carrying {valid, err, data}.
// Data in each stage only moves with a valid response, so the last stage
// holds the previous response value between strobes.
module mem_rd_pipe #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    input  logic             in_err_i,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    output logic             out_err_o,
    output logic [WIDTH-1:0] out_data_o
);

    logic [RD_LAT-1:0] valid_q;
    logic [RD_LAT-1:0] err_q;
    logic [WIDTH-1:0]  data_q [RD_LAT];

    // Shift responses one stage per cycle; reset flushes everything in flight.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            valid_q <= '0;
            err_q   <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                data_q[i] <= '0;
            end
        end else begin
            valid_q[0] <= in_valid_i;
            err_q[0]   <= in_valid_i && in_err_i;
            if (in_valid_i) begin
                data_q[0] <= in_data_i;
            end
            for (int i = 1; i < int'(RD_LAT); i++) begin
                valid_q[i] <= valid_q[i-1];
                err_q[i]   <= err_q[i-1];
                if (valid_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign out_valid_o = valid_q[RD_LAT-1];
    assign out_err_o   = err_q[RD_LAT-1];
    assign out_data_o  = data_q[RD_LAT-1];

endmodule

// File: rtl/mem_hs_pipe.sv
// Single-port valid/ready memory with byte strobes, pipelined read
// responses, out-of-range error strobes and a self-timed clear sweep.
module mem_hs_pipe
    import mem_hs_pipe_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int unsigned RD_LAT     = DEF_RD_LAT
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  wr_rd_en_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [WIDTH-1:0]      wdata_i,
    input  logic [WIDTH/8-1:0]    wstrb_i,
    output logic [WIDTH-1:0]      rdata_o,
    output logic                  rvalid_o,
    output logic                  err_o,
    input  logic                  clear_i,
    output logic                  busy_o
);

    localparam int unsigned            NBYTES    = WIDTH / 8;
    localparam logic [ADDR_WIDTH:0]    DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    // Elaboration-time parameter checks.
    if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
        $error("mem_hs_pipe: RD_LAT must lie in 1..4");
    end
    if ((WIDTH % 8) != 0) begin : g_bad_width
        $error("mem_hs_pipe: WIDTH must be a multiple of 8");
    end
    if (!addr_width_ok(ADDR_WIDTH, DEPTH)) begin : g_bad_addr_width
        $error("mem_hs_pipe: ADDR_WIDTH too small for DEPTH");
    end

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rdy_en_q;
    logic                  wr_err_q;
    logic [WIDTH-1:0]      mem_q [DEPTH];

    logic             in_range;
    logic             accept;
    logic             wr_fire;
    logic             rd_fire;
    logic [WIDTH-1:0] rd_data;
    logic             pipe_err;

    // Comparison is done one bit wider so DEPTH == 2**ADDR_WIDTH still works.
    assign in_range = {1'b0, addr_i} < DEPTH_LIM;
    assign ready_o  = rdy_en_q && (state_q == ST_IDLE) && !clear_i;
    assign accept   = valid_i && ready_o;
    assign wr_fire  = accept && wr_rd_en_i;
    assign rd_fire  = accept && !wr_rd_en_i;
    assign rd_data  = in_range ? mem_q[addr_i] : '0;
    assign busy_o   = (state_q == ST_CLEAR);

    // State, sweep counter, ready enable and write-error strobe registers.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            rdy_en_q <= 1'b0;
            wr_err_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rdy_en_q <= 1'b1;
            wr_err_q <= wr_fire && !in_range;
        end
    end

    // Next-state logic: IDLE serves requests, CLEAR walks every address once.
    // NOTE: defaults first so every path assigns every output and no latch forms.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (clear_i) begin
                    state_d = ST_CLEAR;
                    cnt_d   = '0;
                end
            end
            ST_CLEAR: begin
                if (cnt_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Storage array: sweep writes zero, accepted in-range writes honour strobes.
    // NOTE: the array has no reset; it is plain RAM initialised only by the sweep.
    always_ff @(posedge clk_i) begin
        if (state_q == ST_CLEAR) begin
            mem_q[cnt_q] <= '0;
        end else if (wr_fire && in_range) begin
            for (int b = 0; b < int'(NBYTES); b++) begin
                if (wstrb_i[b]) begin
                    mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    mem_rd_pipe #(
        .WIDTH  (WIDTH),
        .RD_LAT (RD_LAT)
    ) u_rd_pipe (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (rd_fire),
        .in_err_i    (!in_range),
        .in_data_i   (rd_data),
        .out_valid_o (rvalid_o),
        .out_err_o   (pipe_err),
        .out_data_o  (rdata_o)
    );

    assign err_o = pipe_err || wr_err_q;

endmodule
